// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, flag indices and opcode enum for the alu
package alu_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int OPER_WIDTH  = 4;
    localparam int FLAGS_WIDTH = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [OPER_WIDTH-1:0] {
        OP_ADD   = 4'd0,
        OP_ADC   = 4'd1,
        OP_SUB   = 4'd2,
        OP_SBC   = 4'd3,
        OP_CMP   = 4'd4,
        OP_AND   = 4'd5,
        OP_ORR   = 4'd6,
        OP_XOR   = 4'd7,
        OP_LSL   = 4'd8,
        OP_LSR   = 4'd9,
        OP_ASR   = 4'd10,
        OP_ROL   = 4'd11,
        OP_ROR   = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_oper_t;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode/flags bundle between the CPU datapath and the alu
interface alu_if;
    import alu_pkg::*;

    logic [OPER_WIDTH-1:0]  oper;
    logic [DATA_WIDTH-1:0]  a_in;
    logic [DATA_WIDTH-1:0]  b_in;
    logic [FLAGS_WIDTH-1:0] proc_flags_in;
    logic [DATA_WIDTH-1:0]  out;
    logic [FLAGS_WIDTH-1:0] proc_flags_out;

    modport master (
        output oper, a_in, b_in, proc_flags_in,
        input  out, proc_flags_out
    );

    modport slave (
        input  oper, a_in, b_in, proc_flags_in,
        output out, proc_flags_out
    );

endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational shifts (lsl/lsr/asr) and plain rotates (rol/ror)
module alu_shifter
    import alu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] count_i,
    input  alu_oper_t             op_i,
    input  logic                  c_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  c_o
);

    logic        big;
    logic [3:0]  eff;
    logic [2:0]  rot;
    logic [15:0] wide;
    logic [16:0] sext;

    always_comb begin
        result_o = a_i;
        c_o      = c_i;
        big      = (count_i > 8'd8);
        eff      = (count_i >= 8'd8) ? 4'd8 : count_i[3:0];
        rot      = count_i[2:0];
        wide     = 16'h0000;
        sext     = 17'h00000;
        case (op_i)
            OP_LSL: if (count_i != 8'd0) begin
                wide     = {8'h00, a_i} << eff;
                result_o = wide[7:0];
                c_o      = big ? 1'b0 : wide[8];
            end
            OP_LSR: if (count_i != 8'd0) begin
                wide     = {a_i, 8'h00} >> eff;
                result_o = wide[15:8];
                c_o      = big ? 1'b0 : wide[7];
            end
            // Sign bits pre-extended above a so a plain right shift acts arithmetic.
            OP_ASR: if (count_i != 8'd0) begin
                sext     = {{8{a_i[7]}}, a_i, 1'b0} >> eff;
                result_o = sext[8:1];
                c_o      = sext[0];
            end
            OP_ROL: if (rot != 3'd0) begin
                wide     = {a_i, a_i} << rot;
                result_o = wide[15:8];
                c_o      = wide[8];
            end
            OP_ROR: if (rot != 3'd0) begin
                wide     = {a_i, a_i} >> rot;
                result_o = wide[7:0];
                c_o      = wide[7];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 8-bit ALU producing result and {N,V,C,Z} flags with 1-cycle latency
module alu
    import alu_pkg::*;
(
    input  logic  master_clk,
    input  logic  reset,
    alu_if.slave  bus
);

    alu_oper_t              op;
    logic [DATA_WIDTH-1:0]  a, b, b_eff;
    logic [FLAGS_WIDTH-1:0] f_in;
    logic                   is_sub, c_arith;
    logic [DATA_WIDTH:0]    sum;
    logic                   v_arith;
    logic [DATA_WIDTH-1:0]  sh_result;
    logic                   sh_c;

    logic [DATA_WIDTH-1:0]  out_d, out_q, res;
    logic [FLAGS_WIDTH-1:0] flags_d, flags_q;

    assign op   = alu_oper_t'(bus.oper);
    assign a    = bus.a_in;
    assign b    = bus.b_in;
    assign f_in = bus.proc_flags_in;

    // Subtraction reuses the adder as a + ~b + carry-in.
    assign is_sub  = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    assign b_eff   = is_sub ? ~b : b;
    assign c_arith = (op == OP_SUB) || (op == OP_CMP) ||
                     (((op == OP_ADC) || (op == OP_SBC)) && f_in[FLAG_C]);
    assign sum     = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, c_arith};
    assign v_arith = (a[7] == b_eff[7]) && (sum[7] != a[7]);

    alu_shifter u_shifter (
        .a_i      (a),
        .count_i  (b),
        .op_i     (op),
        .c_i      (f_in[FLAG_C]),
        .result_o (sh_result),
        .c_o      (sh_c)
    );

    always_comb begin
        res     = a;
        out_d   = a;
        flags_d = f_in;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                res             = sum[7:0];
                out_d           = (op == OP_CMP) ? a : sum[7:0];
                flags_d[FLAG_C] = sum[8];
                flags_d[FLAG_V] = v_arith;
            end
            OP_AND: begin res = a & b; out_d = res; end
            OP_ORR: begin res = a | b; out_d = res; end
            OP_XOR: begin res = a ^ b; out_d = res; end
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
                res             = sh_result;
                out_d           = sh_result;
                flags_d[FLAG_C] = sh_c;
            end
            default: ;
        endcase
        // Reserved opcodes leave the incoming flags untouched, N and Z included.
        if (op < OP_RSV13) begin
            flags_d[FLAG_N] = res[7];
            flags_d[FLAG_Z] = (res == '0);
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign bus.out            = out_q;
    assign bus.proc_flags_out = flags_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for the registered alu
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    alu_if bus ();

    alu dut (
        .master_clk (clk),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
        logic [7:0] eo;
        logic [3:0] ef;
    } vec_t;

    // Reference: returns {flags, out}; shifts are done one bit at a time.
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] f);
        int         sum;
        logic [7:0] bi, r, o;
        logic       ci, c, v;
        c = f[1];
        v = f[2];
        r = a;
        if (op >= 4'd13) return {f, a};
        if (op <= 4'd4) begin
            bi  = (op >= 4'd2) ? ~b : b;
            ci  = (op == 4'd0) ? 1'b0 : (op == 4'd2 || op == 4'd4) ? 1'b1 : f[1];
            sum = int'(a) + int'(bi) + int'(ci);
            r   = sum[7:0];
            c   = (sum > 255);
            v   = (a[7] == bi[7]) && (r[7] != a[7]);
        end else if (op == 4'd5) r = a & b;
        else if (op == 4'd6) r = a | b;
        else if (op == 4'd7) r = a ^ b;
        else if (op == 4'd8) for (int j = 0; j < int'(b); j++) begin c = r[7]; r = r << 1; end
        else if (op == 4'd9) for (int j = 0; j < int'(b); j++) begin c = r[0]; r = r >> 1; end
        else if (op == 4'd10) for (int j = 0; j < int'(b); j++) begin c = r[0]; r = {r[7], r[7:1]}; end
        else if (op == 4'd11) for (int j = 0; j < int'(b % 8); j++) begin r = {r[6:0], r[7]}; c = r[0]; end
        else for (int j = 0; j < int'(b % 8); j++) begin r = {r[0], r[7:1]}; c = r[7]; end
        o = (op == 4'd4) ? a : r;
        return {r[7], v, c, (r == 8'h00), o};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] f);
        bus.oper          = op;
        bus.a_in          = a;
        bus.b_in          = b;
        bus.proc_flags_in = f;
    endtask

    task automatic test_reset();
        drive(4'd0, 8'hFF, 8'h01, 4'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        checks_total++;
        if ({bus.proc_flags_out, bus.out} !== 12'h000)
            $display("FAIL reset_hold out=%h flags=%b expected out=00 flags=0000",
                     bus.out, bus.proc_flags_out);
        else checks_passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        checks_total++;
        if ({bus.proc_flags_out, bus.out} !== {4'b0011, 8'h00})
            $display("FAIL reset_release out=%h flags=%b expected out=00 flags=0011",
                     bus.out, bus.proc_flags_out);
        else checks_passed++;
    endtask

    task automatic test_directed();
        vec_t dv[11];
        logic [11:0] exp;
        dv[0]  = '{4'd0,  8'h7F, 8'h01, 4'b0000, 8'h80, 4'b1100};
        dv[1]  = '{4'd1,  8'hFF, 8'h00, 4'b0010, 8'h00, 4'b0011};
        dv[2]  = '{4'd2,  8'h05, 8'h07, 4'b0000, 8'hFE, 4'b1000};
        dv[3]  = '{4'd4,  8'h10, 8'h10, 4'b0000, 8'h10, 4'b0011};
        dv[4]  = '{4'd3,  8'h10, 8'h01, 4'b0000, 8'h0E, 4'b0010};
        dv[5]  = '{4'd5,  8'hF0, 8'h0F, 4'b0110, 8'h00, 4'b0111};
        dv[6]  = '{4'd8,  8'h81, 8'h01, 4'b0000, 8'h02, 4'b0010};
        dv[7]  = '{4'd10, 8'h80, 8'h09, 4'b0000, 8'hFF, 4'b1010};
        dv[8]  = '{4'd11, 8'h81, 8'h01, 4'b0000, 8'h03, 4'b0010};
        dv[9]  = '{4'd12, 8'h01, 8'h08, 4'b0010, 8'h01, 4'b0010};
        dv[10] = '{4'd15, 8'h5A, 8'h33, 4'b1010, 8'h5A, 4'b1010};
        for (int i = 0; i < 11; i++) begin
            drive(dv[i].op, dv[i].a, dv[i].b, dv[i].f);
            exp_q.push_back({dv[i].ef, dv[i].eo});
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            checks_total++;
            if ({bus.proc_flags_out, bus.out} !== exp)
                $display("FAIL directed[%0d] op=%0d out=%h flags=%b expected out=%h flags=%b",
                         i, dv[i].op, bus.out, bus.proc_flags_out, exp[7:0], exp[11:8]);
            else checks_passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a, b;
        logic [3:0]  f;
        logic [11:0] exp;
        int          errs = 0;
        for (int op = 0; op < 16; op++) begin
            for (int cin = 0; cin < 2; cin++) begin
                for (int i = 0; i < 1024; i++) begin
                    a = i[7:0];
                    case (i[9:8])
                        2'd0:    b = {4'h0, i[3:0]};
                        2'd1:    b = 8'hFF - i[7:0];
                        default: b = 8'($urandom);
                    endcase
                    f = 4'($urandom);
                    f[1] = cin[0];
                    drive(op[3:0], a, b, f);
                    exp_q.push_back(model(op[3:0], a, b, f));
                    @(posedge clk); #1;
                    exp = exp_q.pop_front();
                    checks_total++;
                    if ({bus.proc_flags_out, bus.out} !== exp) begin
                        if (errs < 20)
                            $display("FAIL sweep op=%0d a=%h b=%h fin=%b out=%h flags=%b expected out=%h flags=%b",
                                     op, a, b, f, bus.out, bus.proc_flags_out, exp[7:0], exp[11:8]);
                        errs++;
                    end else checks_passed++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
